ysyx_22041752_mdu: RTL and testbench

//  Parametrised iterative multiply/divide unit for the EXU, covering RV64M (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) and the *W word ops.

---
 rtl/ysyx_22041752_mdu.sv | 173 +++++++++++++++++
 tb/tb_ysyx_22041752_mdu.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041752_mdu.sv
// ysyx_22041752_mdu: iterative RV64M multiply/divide unit with word (*W) ops.
// Multiply is shift-add retiring MUL_BPC multiplier bits per cycle. Divide is
// restoring, one quotient bit per cycle. Divide-by-zero and signed overflow
// finish one cycle after accept.
// Optional feature macro: YSYX_22041752_MDU_FASTZERO_EN. When it is defined,
// zero operands also take the one-cycle path.
module ysyx_22041752_mdu #(
  parameter int XLEN    = 64,
  parameter int MUL_BPC = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] DIV_LAST_X = CW'(XLEN - 1);
  localparam logic [CW-1:0] DIV_LAST_W = CW'(31);
  localparam logic [CW-1:0] MUL_LAST_X = CW'(XLEN / MUL_BPC - 1);
  localparam logic [CW-1:0] MUL_LAST_W = CW'(32 / MUL_BPC - 1);
  localparam logic [XLEN-1:0] MIN_X   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W32 = XLEN'($signed(32'h8000_0000));

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  logic              is_div_r, word_r, sel_hi_r, sel_rem_r, neg_r;
  logic [2*XLEN-1:0] mul_mcand, mul_acc, mul_acc_nx, mul_prod;
  logic [XLEN-1:0]   mul_mplr, mul_pick;
  logic [XLEN-1:0]   dvd, rem, dvs, dvd_nx, rem_nx, div_pick, div_fix;
  logic [XLEN:0]     rem_sh, rem_sub;
  logic [XLEN-1:0]   raw_res, final_res;

  logic              accept, is_div_in, a_sg_in, b_sg_in, a_neg, b_neg;
  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, a_sx;
  logic              div0, ovf, special, fast_zero, take_fast, calc_last;
  logic [XLEN-1:0]   special_res, fast_res;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready && !flush;

  // Operand preparation: word truncation/extension, signedness, magnitudes
  // and the one-cycle special cases, all decided from the request itself.
  always_comb begin
    is_div_in = op[2];
    a_sg_in   = is_div_in ? !op[0] : (!word && (op == 3'b001 || op == 3'b010));
    b_sg_in   = is_div_in ? !op[0] : (!word && op == 3'b001);
    a_sx      = word ? XLEN'($signed(src1[31:0])) : src1;
    a_ext     = word ? (a_sg_in ? XLEN'($signed(src1[31:0])) : XLEN'(src1[31:0])) : src1;
    b_ext     = word ? (b_sg_in ? XLEN'($signed(src2[31:0])) : XLEN'(src2[31:0])) : src2;
    a_neg     = a_sg_in && a_ext[XLEN-1];
    b_neg     = b_sg_in && b_ext[XLEN-1];
    a_mag     = a_neg ? ('0 - a_ext) : a_ext;
    b_mag     = b_neg ? ('0 - b_ext) : b_ext;
    div0      = (b_ext == '0);
    ovf       = is_div_in && !op[0] && (a_ext == (word ? MIN_W32 : MIN_X)) && (b_ext == '1);
    special   = is_div_in && (div0 || ovf);
    if (div0) special_res = op[1] ? a_sx : '1;
    else      special_res = op[1] ? '0 : a_sx;
`ifdef YSYX_22041752_MDU_FASTZERO_EN
    fast_zero = is_div_in ? ((a_ext == '0) && !div0) : ((a_ext == '0) || (b_ext == '0));
`else
    fast_zero = 1'b0;
`endif
    take_fast = special || fast_zero;
    fast_res  = special ? special_res : '0;
  end

  // One iteration of both datapaths plus the final sign fix and word extension.
  always_comb begin
    mul_acc_nx = mul_acc;
    for (int i = 0; i < MUL_BPC; i++) begin
      if (mul_mplr[i]) mul_acc_nx = mul_acc_nx + (mul_mcand << i);
    end
    mul_prod = neg_r ? ('0 - mul_acc_nx) : mul_acc_nx;
    mul_pick = sel_hi_r ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];

    rem_sh  = {rem, dvd[XLEN-1]};
    rem_sub = rem_sh - {1'b0, dvs};
    if (!rem_sub[XLEN]) begin
      rem_nx = rem_sub[XLEN-1:0];
      dvd_nx = {dvd[XLEN-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[XLEN-1:0];
      dvd_nx = {dvd[XLEN-2:0], 1'b0};
    end
    div_pick = sel_rem_r ? rem_nx : dvd_nx;
    div_fix  = neg_r ? ('0 - div_pick) : div_pick;

    raw_res   = is_div_r ? div_fix : mul_pick;
    final_res = word_r ? XLEN'($signed(raw_res[31:0])) : raw_res;

    if (is_div_r) calc_last = (cnt == (word_r ? DIV_LAST_W : DIV_LAST_X));
    else          calc_last = (cnt == (word_r ? MUL_LAST_W : MUL_LAST_X));
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; flush overrides every other event.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = take_fast ? DONE : CALC;
      CALC:    if (flush) state_nx = IDLE;
               else if (calc_last) state_nx = DONE;
      DONE:    if (flush || out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: load operands on accept, iterate in CALC, register the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      is_div_r  <= 1'b0;
      word_r    <= 1'b0;
      sel_hi_r  <= 1'b0;
      sel_rem_r <= 1'b0;
      neg_r     <= 1'b0;
      mul_mcand <= '0;
      mul_mplr  <= '0;
      mul_acc   <= '0;
      dvd       <= '0;
      rem       <= '0;
      dvs       <= '0;
      result    <= '0;
    end else if (accept) begin
      cnt       <= '0;
      is_div_r  <= is_div_in;
      word_r    <= word;
      sel_hi_r  <= !is_div_in && !word && (op[1:0] != 2'b00);
      sel_rem_r <= op[1];
      neg_r     <= (is_div_in && op[1]) ? a_neg : (a_neg ^ b_neg);
      mul_mcand <= (2*XLEN)'(a_mag);
      mul_mplr  <= b_mag;
      mul_acc   <= '0;
      dvd       <= word ? (a_mag << (XLEN - 32)) : a_mag;
      rem       <= '0;
      dvs       <= b_mag;
      if (take_fast) result <= fast_res;
    end else if (state == CALC && !flush) begin
      cnt <= cnt + 1'b1;
      if (is_div_r) begin
        dvd <= dvd_nx;
        rem <= rem_nx;
      end else begin
        mul_mcand <= mul_mcand << MUL_BPC;
        mul_mplr  <= mul_mplr >> MUL_BPC;
        mul_acc   <= mul_acc_nx;
      end
      if (calc_last) result <= final_res;
    end
  end

endmodule

// File: tb/tb_ysyx_22041752_mdu.sv
// Directed testbench for ysyx_22041752_mdu (XLEN=64, MUL_BPC=2).
module tb_ysyx_22041752_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'b000;
  logic        word = 1'b0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        busy;

  int tests_run = 0;
  int fails = 0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

`ifdef YSYX_22041752_MDU_FASTZERO_EN
  localparam int ZMUL_LAT = 1;
  localparam int ZDIV_LAT = 1;
`else
  localparam int ZMUL_LAT = 33;
  localparam int ZDIV_LAT = 65;
`endif

  ysyx_22041752_mdu #(.XLEN(64), .MUL_BPC(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .src1(src1), .src2(src2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  o;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  // Issue one op, wait (bounded) for out_valid, return result and latency, then consume it.
  task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res, output int lat);
    @(negedge clk);
    op = o; word = w; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_table(input vec_t v[]);
    logic [63:0] r;
    int lat;
    foreach (v[i]) begin
      run_op(v[i].o, v[i].w, v[i].a, v[i].b, r, lat);
      tests_run++;
      if (r !== v[i].exp) begin
        fails++;
        $display("[TB] FAIL %s result: got %h want %h", v[i].name, r, v[i].exp);
      end
      tests_run++;
      if (lat !== v[i].lat) begin
        fails++;
        $display("[TB] FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({in_ready, out_valid, busy} !== 3'b100 || result !== 64'h0) begin
      fails++;
      $display("[TB] FAIL reset_state: got rdy/vld/busy=%b result=%h want 100 result=0",
               {in_ready, out_valid, busy}, result);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    vec_t v[];
    v = new[5];
    v[0] = '{"mul_7x-3", MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 33};
    v[1] = '{"mulhu_max", MULHU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    v[2] = '{"mulhsu_-1x2", MULHSU, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    v[3] = '{"mulh_min_x2", MULH, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    v[4] = '{"mulhu_big", MULHU, 1'b0, 64'h1_0000_0000, 64'h3_0000_0000, 64'd3, 33};
    run_table(v);
  endtask

  task automatic test_div();
    vec_t v[];
    v = new[8];
    v[0] = '{"div_5/0", DIV, 1'b0, 64'd5, 64'd0, '1, 1};
    v[1] = '{"rem_5/0", REM, 1'b0, 64'd5, 64'd0, 64'd5, 1};
    v[2] = '{"div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
    v[3] = '{"rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1};
    v[4] = '{"div_-7/2", DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    v[5] = '{"rem_-7/2", REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65};
    v[6] = '{"divu_100/7", DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    v[7] = '{"remu_100/7", REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65};
    run_table(v);
  endtask

  task automatic test_word();
    vec_t v[];
    v = new[6];
    v[0] = '{"divw", DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
    v[1] = '{"remw", REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, '1, 33};
    v[2] = '{"divuw", DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, '1, 33};
    v[3] = '{"mulw", MUL, 1'b1, 64'h1234_0000_0001_0000, 64'd32768, 64'hFFFF_FFFF_8000_0000, 17};
    v[4] = '{"mulhw_as_mulw", MULH, 1'b1, 64'h0000_0000_0001_0000, 64'd32768, 64'hFFFF_FFFF_8000_0000, 17};
    v[5] = '{"divuw_by0", DIVU, 1'b1, 64'h5, 64'hFFFF_FFFF_0000_0000, '1, 1};
    run_table(v);
  endtask

  task automatic test_backpressure();
    int lat;
    logic ok;
    @(negedge clk);
    op = MUL; word = 1'b0; src1 = 64'd3; src2 = 64'd5; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && result === 64'd15)) ok = 1'b0;
    end
    tests_run++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL backpressure_hold: got vld=%b rdy=%b result=%h want 1 0 %h",
               out_valid, in_ready, result, 64'd15);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    tests_run++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      fails++;
      $display("[TB] FAIL backpressure_release: got vld/rdy/busy=%b want 010",
               {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_flush_reset();
    logic seen;
    logic [63:0] r;
    int lat;
    // flush at cycle 10 of a divide
    @(negedge clk);
    op = DIVU; word = 1'b0; src1 = 64'd100; src2 = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    tests_run++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      fails++;
      $display("[TB] FAIL flush_calc: got vld/rdy/busy=%b want 010", {out_valid, in_ready, busy});
    end
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush_no_result: got out_valid seen=%b want 0", seen);
    end

    // flush together with in_valid: no accept
    @(negedge clk);
    op = MUL; src1 = 64'd2; src2 = 64'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    tests_run++;
    if ({busy, in_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL flush_with_valid: got busy/rdy=%b want 01", {busy, in_ready});
    end

    // flush in DONE without out_ready, then flush with out_ready
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      op = DIV; src1 = 64'd5; src2 = 64'd0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      flush = 1'b1; out_ready = (k == 1);
      @(posedge clk);
      #1 flush = 1'b0; out_ready = 1'b0;
      tests_run++;
      if ({out_valid, in_ready} !== 2'b01) begin
        fails++;
        $display("[TB] FAIL flush_done_%0d: got vld/rdy=%b want 01", k, {out_valid, in_ready});
      end
    end

    // reset pulse mid-CALC
    @(negedge clk);
    op = MUL; src1 = 64'd9; src2 = 64'd9; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, in_ready, busy} !== 3'b010 || result !== 64'h0) begin
      fails++;
      $display("[TB] FAIL reset_mid_calc: got vld/rdy/busy=%b result=%h want 010 result=0",
               {out_valid, in_ready, busy}, result);
    end
    @(negedge clk);
    reset = 1'b1;
    run_op(MUL, 1'b0, 64'd3, 64'd4, r, lat);
    tests_run++;
    if (r !== 64'd12 || lat !== 33) begin
      fails++;
      $display("[TB] FAIL mul_after_reset: got %h lat %0d want %h lat 33", r, lat, 64'd12);
    end
  endtask

  task automatic test_zero_operands();
    vec_t v[];
    v = new[3];
    v[0] = '{"mul_0xA", MUL, 1'b0, 64'd0, 64'h1234_5678, 64'd0, ZMUL_LAT};
    v[1] = '{"mulhu_Ax0", MULHU, 1'b0, '1, 64'd0, 64'd0, ZMUL_LAT};
    v[2] = '{"div_0/5", DIV, 1'b0, 64'd0, 64'd5, 64'd0, ZDIV_LAT};
    run_table(v);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_word();
    test_backpressure();
    test_flush_reset();
    test_zero_operands();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no finish want finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
